// File: rtl/usb_cmd_fetch.sv
// Command-FIFO fetcher for usb_command_interpreter: reads one word per transaction,
// discards null words, delivers the rest as a held word plus a spaced one-cycle strobe.
module usb_cmd_fetch #(
    parameter int WORD_W     = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [WORD_W-1:0] out_ControlWord,
    output logic              out_Ctr_rd_en,
    output logic              out_busy,
    output logic [CNT_W-1:0]  out_cmd_count,
    output logic [7:0]        out_drop_count,
    output logic [2:0]        dbg_state
);

    // Delivery handshake: out_Ctr_rd_en is a one-cycle strobe with no ready/back-pressure;
    // out_ControlWord is valid in the strobe cycle and held until the next strobe.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    logic [2:0]        state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0] cap_q, cap_d;
    logic              fifo_rd_en_q, fifo_rd_en_d;
    logic [WORD_W-1:0] ctrl_word_q, ctrl_word_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        cap_d        = cap_q;
        fifo_rd_en_d = 1'b0;
        ctrl_word_d  = ctrl_word_q;
        strobe_d     = 1'b0;
        cmd_cnt_d    = cmd_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d      = S_READ;
                    fifo_rd_en_d = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // Deliver/drop is decided on the latch edge so the strobe and the
                // counters are already registered during the ISSUE cycle.
                cap_d   = fifo_dout;
                state_d = S_ISSUE;
                if (fifo_dout != '0) begin
                    ctrl_word_d = fifo_dout;
                    strobe_d    = 1'b1;
                    cmd_cnt_d   = cmd_cnt_q + CNT_W'(1);
                end else if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            S_ISSUE: begin
                gap_cnt_d = '0;
                if (cap_q == '0 || GAP_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            cap_q        <= '0;
            fifo_rd_en_q <= 1'b0;
            ctrl_word_q  <= '0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            cmd_cnt_q    <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            cap_q        <= cap_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            ctrl_word_q  <= ctrl_word_d;
            strobe_q     <= strobe_d;
            busy_q       <= busy_d;
            cmd_cnt_q    <= cmd_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign fifo_rd_en      = fifo_rd_en_q;
    assign out_ControlWord = ctrl_word_q;
    assign out_Ctr_rd_en   = strobe_q;
    assign out_busy        = busy_q;
    assign out_cmd_count   = cmd_cnt_q;
    assign out_drop_count  = drop_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_usb_cmd_fetch.sv
// Bench for usb_cmd_fetch: FIFO model plus scoreboard of expected delivered words,
// directed scenarios followed by randomized traffic.
`timescale 1ns/100ps
module tb_usb_cmd_fetch;

    localparam int WORD_W     = 16;
    localparam int GAP_CYCLES = 4;
    localparam int CNT_W      = 4;
    localparam int SPACING    = GAP_CYCLES + 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [WORD_W-1:0] fifo_dout = '0;
    logic              fifo_rd_en;
    logic [WORD_W-1:0] out_ControlWord;
    logic              out_Ctr_rd_en;
    logic              out_busy;
    logic [CNT_W-1:0]  out_cmd_count;
    logic [7:0]        out_drop_count;
    logic [2:0]        dbg_state;

    usb_cmd_fetch #(.WORD_W(WORD_W), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .out_ControlWord(out_ControlWord),
        .out_Ctr_rd_en(out_Ctr_rd_en), .out_busy(out_busy), .out_cmd_count(out_cmd_count),
        .out_drop_count(out_drop_count), .dbg_state(dbg_state)
    );

    always #12.5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [WORD_W-1:0] fifo_q[$];
    logic [WORD_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic              prev_strobe = 1'b0;
    logic              rd_d1 = 1'b0;
    logic              rd_d2 = 1'b0;
    int                last_strobe_t = -1000;
    logic [WORD_W-1:0] last_word = '0;
    int                mon_delivered = 0;
    int                strobe_t[$];
    int                rd_pulses = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_delivered = 0;
            last_word     = '0;
            prev_strobe   = 1'b0;
            rd_d1         = 1'b0;
            rd_d2         = 1'b0;
            last_strobe_t = -1000;
        end else begin
            if (fifo_rd_en) rd_pulses++;
            if (out_Ctr_rd_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {16'h0, out_ControlWord}, 32'hFFFF_FFFF);
                end else begin
                    last_word = exp_q.pop_front();
                    chk("strobe_word", out_ControlWord, last_word);
                end
                mon_delivered = (mon_delivered + 1) % (1 << CNT_W);
                chk("cmd_count", out_cmd_count, mon_delivered);
                chk("read_to_strobe_latency", rd_d2, 1);
                chk("strobe_not_back_to_back", prev_strobe, 0);
                chk("strobe_min_spacing", (cycle - last_strobe_t) >= SPACING, 1);
                last_strobe_t = cycle;
                strobe_t.push_back(cycle);
            end else begin
                chk("word_hold", out_ControlWord, last_word);
            end
            prev_strobe = out_Ctr_rd_en;
            rd_d2       = rd_d1;
            rd_d1       = fifo_rd_en;
        end
    end

    // ---------------- driver / FIFO model ----------------
    logic [WORD_W-1:0] hold_word = '0;
    logic              show_next = 1'b0;
    int                exp_cmd = 0;
    int                exp_drop = 0;

    // Standard-read FIFO: the word popped by a read shows on fifo_dout one cycle later;
    // otherwise fifo_dout carries junk so early or late capture is visible.
    task automatic step();
        @(negedge clk);
        if (show_next) begin
            fifo_dout = hold_word;
            show_next = 1'b0;
        end else begin
            fifo_dout = WORD_W'($urandom);
        end
        if (fifo_rd_en && reset_n) begin
            chk("read_not_empty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) begin
                hold_word = fifo_q.pop_front();
                show_next = 1'b1;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [WORD_W-1:0] w);
        fifo_q.push_back(w);
        if (w != '0) begin
            exp_q.push_back(w);
            exp_cmd++;
        end else begin
            exp_drop++;
        end
        fifo_empty = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && !show_next && !out_busy && !fifo_rd_en) && n < budget) begin
            step();
            n++;
        end
        chk("drain_within_budget", n < budget, 1);
        step();
        step();
    endtask

    task automatic checkpoint();
        chk("cp_cmd_count", out_cmd_count, exp_cmd % (1 << CNT_W));
        chk("cp_drop_count", out_drop_count, (exp_drop > 255) ? 255 : exp_drop);
        chk("cp_all_delivered", exp_q.size(), 0);
        chk("cp_not_busy", out_busy, 0);
    endtask

    initial begin
        int sb;
        int rb;
        int n;
        logic [WORD_W-1:0] w;

        // Reset held 200 ns with the FIFO non-empty and fetching enabled.
        reset_n = 1'b0;
        push(16'h55AA);
        enable = 1'b1;
        repeat (8) step();
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_strobe", out_Ctr_rd_en, 0);
        chk("rst_ctrl_word", out_ControlWord, 0);
        chk("rst_cmd_count", out_cmd_count, 0);
        chk("rst_drop_count", out_drop_count, 0);
        chk("rst_busy", out_busy, 0);

        // Single word: delivered after release.
        sb = strobe_t.size();
        rb = rd_pulses;
        reset_n = 1'b1;
        wait_idle(100);
        chk("single_strobes", strobe_t.size() - sb, 1);
        chk("single_reads", rd_pulses - rb, 1);
        chk("single_word_held", out_ControlWord, 16'h55AA);
        checkpoint();

        // Back-to-back words arrive exactly GAP_CYCLES+4 apart.
        enable = 1'b0;
        push(16'h55AA); push(16'hFFC0); push(16'hFFD0);
        enable = 1'b1;
        sb = strobe_t.size();
        rb = rd_pulses;
        wait_idle(200);
        chk("b2b_strobes", strobe_t.size() - sb, 3);
        chk("b2b_reads", rd_pulses - rb, 3);
        if (strobe_t.size() - sb == 3) begin
            chk("b2b_spacing_1", strobe_t[sb+1] - strobe_t[sb], SPACING);
            chk("b2b_spacing_2", strobe_t[sb+2] - strobe_t[sb+1], SPACING);
        end
        checkpoint();

        // Null drop: the dropped word costs IDLE/READ/LATCH/ISSUE (4 cycles) and no gap.
        enable = 1'b0;
        push(16'h55AA); push(16'h0000); push(16'hFFC0);
        enable = 1'b1;
        sb = strobe_t.size();
        wait_idle(200);
        chk("drop_strobes", strobe_t.size() - sb, 2);
        if (strobe_t.size() - sb == 2)
            chk("drop_spacing", strobe_t[sb+1] - strobe_t[sb], SPACING + 4);
        checkpoint();

        // Enable withdrawn in the READ cycle of 0xFFC0 while 0xFFD0 is queued.
        enable = 1'b0;
        push(16'hFFC0); push(16'hFFD0);
        enable = 1'b1;
        sb = strobe_t.size();
        n = 0;
        do begin
            step();
            n++;
        end while (!fifo_rd_en && n < 20);
        chk("withdraw_read_seen", fifo_rd_en, 1);
        enable = 1'b0;
        step();
        rb = rd_pulses;
        repeat (30) step();
        chk("withdraw_no_new_read", rd_pulses - rb, 0);
        chk("withdraw_inflight_done", strobe_t.size() - sb, 1);
        chk("withdraw_word_still_queued", fifo_q.size(), 1);
        enable = 1'b1;
        wait_idle(100);
        chk("withdraw_resume_strobes", strobe_t.size() - sb, 2);
        chk("withdraw_last_word", out_ControlWord, 16'hFFD0);
        checkpoint();

        // Randomized traffic with random enable; counter wraps at 2^CNT_W.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                w = ($urandom_range(0, 5) == 0) ? '0 : WORD_W'($urandom_range(1, 16'hFFFF));
                push(w);
            end
            enable = ($urandom_range(0, 4) != 0);
            step();
        end
        enable = 1'b1;
        wait_idle(3000);
        checkpoint();

        // Drop counter saturates at 255.
        for (int i = 0; i < 300; i++) push('0);
        wait_idle(3000);
        checkpoint();

        // Reset during the gap after 0x55AA; 0xFFC0 still queued in the FIFO.
        push(16'h55AA); push(16'hFFC0);
        sb = strobe_t.size();
        n = 0;
        while (strobe_t.size() == sb && n < 40) begin
            step();
            n++;
        end
        chk("rif_first_strobe", strobe_t.size() - sb, 1);
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("rif_fifo_rd_en", fifo_rd_en, 0);
        chk("rif_strobe", out_Ctr_rd_en, 0);
        chk("rif_ctrl_word", out_ControlWord, 0);
        chk("rif_cmd_count", out_cmd_count, 0);
        chk("rif_drop_count", out_drop_count, 0);
        chk("rif_busy", out_busy, 0);
        exp_cmd   = 0;
        exp_drop  = 0;
        show_next = 1'b0;
        exp_q.delete();
        foreach (fifo_q[k]) begin
            if (fifo_q[k] == '0) exp_drop++;
            else exp_q.push_back(fifo_q[k]);
        end
        step();
        step();
        reset_n = 1'b1;
        wait_idle(100);
        chk("rif_resume_word", out_ControlWord, 16'hFFC0);
        exp_cmd = 1;
        checkpoint();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
